// File: rtl/vga_sync_recover.sv
// Rebuilds hcnt/vcnt from incoming active-low hsync/vsync, measures line length and tracks lock.
// Define VGA_IN_SYNC_EN to add a 2-flop synchronizer on both sync inputs (2 extra cycles latency).
module vga_sync_recover #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned LOCK_LINES   = 4
) (
  input  logic        clk25m,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  hcnt,
  output logic [9:0]  vcnt,
  output logic        active,
  output logic        locked,
  output logic [10:0] line_len,
  output logic        frame_start,
  output logic [7:0]  err_cnt
);

  localparam logic [9:0]  HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  HSync     = 10'(H_SYNC_START);
  localparam logic [9:0]  HAct      = 10'(H_ACTIVE);
  localparam logic [9:0]  VLast     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VSync     = 10'(V_SYNC_START);
  localparam logic [9:0]  VAct      = 10'(V_ACTIVE);
  localparam logic [10:0] HTot      = 11'(H_TOTAL);
  localparam logic [10:0] PerMax    = 11'h7ff;
  localparam logic [10:0] VtoLines  = 11'(2 * V_TOTAL);
  localparam logic [3:0]  LockLines = 4'(LOCK_LINES);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  state_e      state;
  logic        hs_s, vs_s;
  logic        hs_prev, vs_prev;
  logic [10:0] per_cnt;
  logic [10:0] wrap_cnt;
  logic [3:0]  good_cnt;
  logic        hs_fall, vs_fall, h_wrap;
  logic        good_line, bad_line, hsync_to, vsync_to, lose_lock;

`ifdef VGA_IN_SYNC_EN
  logic [1:0] hs_sync, vs_sync;

  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      hs_sync <= 2'b11;
      vs_sync <= 2'b11;
    end else begin
      hs_sync <= {hs_sync[0], hsync_in};
      vs_sync <= {vs_sync[0], vsync_in};
    end
  end

  assign hs_s = hs_sync[1];
  assign vs_s = vs_sync[1];
`else
  assign hs_s = hsync_in;
  assign vs_s = vsync_in;
`endif

  assign hs_fall   = hs_prev & ~hs_s;
  assign vs_fall   = vs_prev & ~vs_s;
  assign h_wrap    = (hcnt == HLast) & ~hs_fall;
  assign good_line = (per_cnt == HTot);
  assign bad_line  = hs_fall & ~good_line;
  assign hsync_to  = (per_cnt == PerMax);
  assign vsync_to  = (wrap_cnt >= VtoLines);
  assign lose_lock = (state == StLocked) & (bad_line | hsync_to | vsync_to);

  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev  <= 1'b1;
      vs_prev  <= 1'b1;
      hcnt     <= '0;
      vcnt     <= '0;
      per_cnt  <= '0;
      line_len <= '0;
      wrap_cnt <= '0;
    end else begin
      hs_prev <= hs_s;
      vs_prev <= vs_s;

      if (hs_fall)            hcnt <= HSync;
      else if (hcnt == HLast) hcnt <= '0;
      else                    hcnt <= hcnt + 10'd1;

      // vsync fall wins over the end-of-line increment
      if (vs_fall)     vcnt <= VSync;
      else if (h_wrap) vcnt <= (vcnt == VLast) ? '0 : vcnt + 10'd1;

      if (hs_fall) begin
        per_cnt  <= 11'd1;
        line_len <= per_cnt;
      end else if (!hsync_to) begin
        per_cnt <= per_cnt + 11'd1;
      end

      if (vs_fall || state != StLocked) wrap_cnt <= '0;
      else if (h_wrap && !vsync_to)     wrap_cnt <= wrap_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StSearch;
      good_cnt    <= '0;
      locked      <= 1'b0;
      err_cnt     <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      case (state)
        StSearch: begin
          if (hs_fall) begin
            state    <= StTrack;
            good_cnt <= '0;
          end
        end
        StTrack: begin
          if (hsync_to) begin
            state <= StSearch;
          end else begin
            if (hs_fall) begin
              if (!good_line)              good_cnt <= '0;
              else if (good_cnt != 4'hf)   good_cnt <= good_cnt + 4'd1;
            end
            if (vs_fall && good_cnt >= LockLines) begin
              state  <= StLocked;
              locked <= 1'b1;
            end
          end
        end
        StLocked: begin
          if (lose_lock) begin
            state  <= StSearch;
            locked <= 1'b0;
            if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
          end
        end
        default: state <= StSearch;
      endcase

      // gated by lose_lock so neither output outlives locked
      active      <= locked & ~lose_lock & (hcnt < HAct) & (vcnt < VAct);
      frame_start <= locked & ~lose_lock & (hcnt == HLast) & (vcnt == VLast);
    end
  end

endmodule

// File: tb/tb_vga_sync_recover.sv
// Directed bench for vga_sync_recover on a scaled-down 16x8 raster driven by an inline generator.
module tb_vga_sync_recover;

  localparam int HA = 8;
  localparam int HS = 10;
  localparam int HT = 16;
  localparam int HW = 2;
  localparam int VA = 4;
  localparam int VS = 5;
  localparam int VT = 8;
  localparam int VW = 2;
`ifdef VGA_IN_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic        clk25m = 1'b0;
  logic        rst_n = 1'b1;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [9:0]  hcnt, vcnt;
  logic        active, locked, frame_start;
  logic [10:0] line_len;
  logic [7:0]  err_cnt;

  vga_sync_recover #(
    .H_ACTIVE(HA), .H_SYNC_START(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VS), .V_TOTAL(VT), .LOCK_LINES(4)
  ) dut (
    .clk25m(clk25m), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hcnt(hcnt), .vcnt(vcnt), .active(active), .locked(locked),
    .line_len(line_len), .frame_start(frame_start), .err_cnt(err_cnt)
  );

  always #5 clk25m = ~clk25m;

  int   n_tests = 0;
  int   n_fail = 0;
  int   gh = 0, gv = 0;
  bit   hold_h = 0, hold_v = 0, short_line = 0;
  int   short_v = 6;
  int   hist_h[3] = '{-1, -1, -1};
  int   hist_v[3] = '{-1, -1, -1};
  int   dh = -1, dv = -1, pdh = -1, pdv = -1;
  logic prev_locked = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    hsync_in = hold_h || !(gh >= HS && gh < HS + HW);
    vsync_in = hold_v || !(gv >= VS && gv < VS + VW);
  endtask

  // dh/dv: generator position the DUT should be showing after this edge
  task automatic step();
    prev_locked = locked;
    pdh = dh;
    pdv = dv;
    @(posedge clk25m);
    hist_h[2] = hist_h[1]; hist_h[1] = hist_h[0]; hist_h[0] = gh;
    hist_v[2] = hist_v[1]; hist_v[1] = hist_v[0]; hist_v[0] = gv;
    #1;
    dh = hist_h[Lat];
    dv = hist_v[Lat];
    if (gh == HT - 1 || (short_line && gv == short_v && gh == HT - 2)) begin
      gh = 0;
      gv = (gv == VT - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
    drive();
  endtask

  task automatic wait_pos(input int h, input int v, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (dh == h && dv == v) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_lock(input logic want, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (locked === want) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int pos_bad, act_bad, fs_bad, fs_n, act_n;
    logic exp_act, exp_fs;

    drive();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk25m);
    #1;
    check("rst_hcnt", hcnt, 0);
    check("rst_vcnt", vcnt, 0);
    check("rst_active", active, 0);
    check("rst_locked", locked, 0);
    check("rst_line_len", line_len, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;

    // lines 0..4 give one start fall plus 4 good lines; lock lands on the vsync fall at line 5
    wait_pos(0, 5, 200, n);
    check("lock_reached", n > 0, 1);
    check("lock_prev_cycle", prev_locked, 0);
    check("lock_at_vsync", locked, 1);
    check("line_len_clean", line_len, 16);

    pos_bad = 0; act_bad = 0; fs_bad = 0; fs_n = 0; act_n = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step();
      if (hcnt !== 10'(dh) || vcnt !== 10'(dv)) pos_bad++;
      exp_act = (pdh < HA) && (pdv < VA);
      exp_fs  = (pdh == HT - 1) && (pdv == VT - 1);
      if (active !== exp_act) act_bad++;
      if (frame_start !== exp_fs) fs_bad++;
      if (active) act_n++;
      if (frame_start) fs_n++;
    end
    check("track_pos_errors", pos_bad, 0);
    check("active_errors", act_bad, 0);
    check("frame_start_errors", fs_bad, 0);
    check("frame_start_count", fs_n, 2);
    check("active_count", act_n, 2 * HA * VA);

    // line 6 is 15 clocks, so the line-7 hsync fall is a bad line
    short_line = 1;
    wait_pos(10, 7, 200, n);
    short_line = 0;
    check("short_reached", n > 0, 1);
    check("short_prev_locked", prev_locked, 1);
    check("short_locked", locked, 0);
    check("short_line_len", line_len, 15);
    check("short_err_cnt", err_cnt, 1);
    check("short_active", active, 0);
    wait_pos(0, 5, 200, n);
    check("short_relock_reached", n > 0, 1);
    check("short_relocked", locked, 1);
    check("short_err_hold", err_cnt, 1);

    // period counter is 7 here; it saturates 2040 edges later, lock drops on the next edge
    hold_h = 1;
    wait_lock(1'b0, 3000, n);
    check("hsync_to_cycles", n, 2041);
    check("hsync_to_err_cnt", err_cnt, 2);
    check("hsync_to_line_len", line_len, 16);
    check("hsync_to_active", active, 0);
    hold_h = 0;
    wait_lock(1'b1, 400, n);
    check("hsync_relock", n > 0, 1);

    // 16 line wraps land on the 256th edge; timeout acts on the next
    hold_v = 1;
    wait_lock(1'b0, 400, n);
    check("vsync_to_cycles", n, 257);
    check("vsync_to_err_cnt", err_cnt, 3);
    hold_v = 0;
    wait_lock(1'b1, 400, n);
    check("vsync_relock", n > 0, 1);

    wait_pos(4, 1, 200, n);
    check("mid_line_reached", n > 0, 1);
    check("pre_reset_active", active, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hcnt", hcnt, 0);
    check("async_rst_vcnt", vcnt, 0);
    check("async_rst_active", active, 0);
    check("async_rst_locked", locked, 0);
    check("async_rst_line_len", line_len, 0);
    check("async_rst_frame_start", frame_start, 0);
    check("async_rst_err_cnt", err_cnt, 0);
    step();
    step();
    rst_n = 1'b1;
    wait_lock(1'b1, 400, n);
    check("post_reset_relock", n > 0, 1);
    check("post_reset_err_cnt", err_cnt, 0);

    // one loss per 127-cycle frame: 10 within the first 1280 cycles
    short_line = 1;
    repeat (1280) step();
    check("loss_count_10", err_cnt, 10);
    repeat (32000) step();
    check("err_cnt_saturated", err_cnt, 255);
    short_line = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
